// File: rtl/axis_frame_capture.sv
// AXI4-Stream sink: captures DEPTH samples into RAM after skipping SKIP_FRAMES frames, with a tlast framing check.
// Optional macro AXIS_FRAME_CAPTURE_SOF_ALIGN_EN starts capture on a frame boundary via a SYNC state.
module axis_frame_capture #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 64,
  parameter int FRAME_LEN   = 64,
  parameter int SKIP_FRAMES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic [2*WIDTH-1:0]       s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [2*WIDTH-1:0]       rd_data,
  output logic                     full,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   wr_count,
  output logic                     tlast_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int FW = $clog2(SKIP_FRAMES + 2);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(FRAME_LEN - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(SKIP_FRAMES - 1);
  localparam logic [AW:0]   WR_LAST    = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   WR_FULL    = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    SKIP    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam state_t FIRST_FRAME_STATE = (SKIP_FRAMES > 0) ? SKIP : CAPTURE;
`ifdef AXIS_FRAME_CAPTURE_SOF_ALIGN_EN
  localparam state_t START_STATE = SYNC;
`else
  localparam state_t START_STATE = FIRST_FRAME_STATE;
`endif

  state_t            state, next_state;
  logic              beat, start, checking, wr_en;
  logic [BW-1:0]     beat_cnt;
  logic [FW-1:0]     frame_cnt;
  logic [2*WIDTH-1:0] mem [DEPTH];

  // Upstream is never stalled; beats outside a capture are simply dropped.
  assign s_axis_tready = ~rst;
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign start         = arm && ((state == IDLE) || (state == DONE));
  assign checking      = (state == SKIP) || (state == CAPTURE);
  assign wr_en         = beat && (state == CAPTURE) && (wr_count != WR_FULL);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (arm) next_state = START_STATE;
        else     next_state = state;
      end
`ifdef AXIS_FRAME_CAPTURE_SOF_ALIGN_EN
      SYNC: begin
        if (beat && s_axis_tlast) next_state = FIRST_FRAME_STATE;
        else                      next_state = state;
      end
`endif
      SKIP: begin
        if (beat && s_axis_tlast && (frame_cnt == FRAME_LAST)) next_state = CAPTURE;
        else                                                   next_state = state;
      end
      CAPTURE: begin
        if (wr_en && (wr_count == WR_LAST)) next_state = DONE;
        else                                next_state = state;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      full      <= 1'b0;
      wr_count  <= '0;
      tlast_err <= 1'b0;
      beat_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      busy <= (next_state == SYNC) || (next_state == SKIP) || (next_state == CAPTURE);
      full <= (next_state == DONE);
      if (start) begin
        wr_count  <= '0;
        tlast_err <= 1'b0;
        beat_cnt  <= '0;
        frame_cnt <= '0;
      end else begin
        if (wr_en) wr_count <= wr_count + 1'b1;
        // Error when tlast disagrees with the expected last-beat position of the frame.
        if (checking && beat && (s_axis_tlast != (beat_cnt == BEAT_LAST))) tlast_err <= 1'b1;
        if ((state == SYNC) && beat && s_axis_tlast)
          beat_cnt <= '0;
        else if (checking && beat)
          beat_cnt <= (s_axis_tlast || (beat_cnt == BEAT_LAST)) ? '0 : beat_cnt + 1'b1;
        if ((state == SKIP) && beat && s_axis_tlast) frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_count[AW-1:0]] <= s_axis_tdata;
  end

  // Read port returns pre-write data on an address collision.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_axis_frame_capture.sv
// Bench for axis_frame_capture: two instances (SKIP_FRAMES 0 and 2) fed from one counter stream,
// scoreboard queues of expected RAM contents filled at arm time, table of capture scenarios.
module tb_axis_frame_capture;
  localparam int W  = 16;
  localparam int D  = 64;
  localparam int FL = 64;

  logic              clk = 1'b0;
  logic              rst, arm, tvalid, tlast;
  logic [2*W-1:0]    tdata;
  logic [5:0]        rd_addr;
  logic [1:0]        tready_v, full_v, busy_v, err_v;
  logic [6:0]        wrc_v [2];
  logic [2*W-1:0]    rdd_v [2];

  always #5 clk = ~clk;

  axis_frame_capture #(.WIDTH(W), .DEPTH(D), .FRAME_LEN(FL), .SKIP_FRAMES(0)) dut (
    .clk(clk), .rst(rst), .arm(arm), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tready(tready_v[0]), .rd_addr(rd_addr), .rd_data(rdd_v[0]),
    .full(full_v[0]), .busy(busy_v[0]), .wr_count(wrc_v[0]), .tlast_err(err_v[0]));

  axis_frame_capture #(.WIDTH(W), .DEPTH(D), .FRAME_LEN(FL), .SKIP_FRAMES(2)) dut_skip (
    .clk(clk), .rst(rst), .arm(arm), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tready(tready_v[1]), .rd_addr(rd_addr), .rd_data(rdd_v[1]),
    .full(full_v[1]), .busy(busy_v[1]), .wr_count(wrc_v[1]), .tlast_err(err_v[1]));

  typedef struct {
    int arm_off;   // stream value at the arm cycle
    bit gap;       // 50% random tvalid
    bit inject;    // stray tlast 30 beats into the first captured frame
    int rst_at;    // main wr_count at which reset hits (0 = never)
    bit chk_skip;  // check the SKIP_FRAMES=2 instance too
    bit err_nm;    // expected tlast_err without frame alignment
  } vec_t;

  vec_t tbl [5];
  int   total = 0;
  int   bad   = 0;
  int   v, inj_val;
  bit   inj_on, m_armed;
  int   m_start [2];
  int   m_wr    [2];
  int   skipf   [2];
  int   q0 [$];
  int   q1 [$];

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h want=%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic int exp_start(input int first, input int skip);
`ifdef AXIS_FRAME_CAPTURE_SOF_ALIGN_EN
    return (first / FL + 1 + skip) * FL;
`else
    if (skip == 0) return first;
    else           return (first / FL + skip) * FL;
`endif
  endfunction

  // One clock: inputs applied at the negedge, model updated at the posedge, outputs sampled at the next negedge.
  task automatic step(input bit valid, input bit do_arm);
    arm    = do_arm;
    tvalid = valid;
    if (do_arm) begin
      tdata = 32'hFFFF_FFFF;
      tlast = 1'b0;
    end else begin
      tdata = 32'(v);
      tlast = ((v % FL) == FL - 1) || (inj_on && (v == inj_val));
    end
    @(posedge clk);
    if (do_arm) begin
      m_armed = 1'b1;
      q0.delete();
      q1.delete();
      for (int d = 0; d < 2; d++) begin
        m_start[d] = exp_start(v, skipf[d]);
        m_wr[d]    = 0;
      end
      for (int k = 0; k < D; k++) begin
        q0.push_back(m_start[0] + k);
        q1.push_back(m_start[1] + k);
      end
    end else if (valid) begin
      for (int d = 0; d < 2; d++)
        if (m_armed && (v >= m_start[d]) && (m_wr[d] < D)) m_wr[d]++;
      v++;
    end
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic check_state(input int d);
    chk("wr_count", d, 64'(wrc_v[d]), 64'(m_wr[d]));
    chk("full",     d, 64'(full_v[d]), 64'(m_wr[d] == D));
    chk("busy",     d, 64'(busy_v[d]), 64'(m_armed && (m_wr[d] < D)));
    chk("tready",   d, 64'(tready_v[d]), 64'd1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; arm = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0; rd_addr = '0;
    repeat (n) @(negedge clk);
    m_armed = 1'b0;
    m_wr[0] = 0;
    m_wr[1] = 0;
  endtask

  initial begin
    int  cyc, e0, e1;
    bit  rst_done, exp_err;
    skipf[0] = 0;
    skipf[1] = 2;
    inj_on   = 1'b0;
    inj_val  = 0;
    tbl[0] = '{0,  1'b0, 1'b0, 0,  1'b1, 1'b0};
    tbl[1] = '{0,  1'b0, 1'b1, 0,  1'b0, 1'b1};
    tbl[2] = '{0,  1'b1, 1'b0, 0,  1'b1, 1'b0};
    tbl[3] = '{0,  1'b0, 1'b0, 20, 1'b1, 1'b0};
    tbl[4] = '{10, 1'b0, 1'b0, 0,  1'b1, 1'b1};

    // Reset state and beats dropped while idle.
    do_reset(10);
    for (int d = 0; d < 2; d++) begin
      chk("rst_tready", d, 64'(tready_v[d]), 64'd0);
      chk("rst_full",   d, 64'(full_v[d]), 64'd0);
      chk("rst_err",    d, 64'(err_v[d]), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("idle_rd_data", d, 64'(rdd_v[d]), 64'd0);
      check_state(d);
    end
    v = 0;
    repeat (20) begin
      step(1'b1, 1'b0);
      check_state(0);
      check_state(1);
    end

    for (int r = 0; r < 5; r++) begin
      do_reset(2);
      rst      = 1'b0;
      v        = tbl[r].arm_off;
      inj_on   = tbl[r].inject;
      rst_done = 1'b0;
      step(1'b1, 1'b1);
      inj_val = m_start[0] + 30;
      cyc = 0;
      while (!((m_wr[0] == D) && (!tbl[r].chk_skip || (m_wr[1] == D))) && (cyc < 1500)) begin
        step(tbl[r].gap ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
        check_state(0);
        if (tbl[r].chk_skip) check_state(1);
        if ((tbl[r].rst_at != 0) && !rst_done && (m_wr[0] == tbl[r].rst_at)) begin
          rst_done = 1'b1;
          rst = 1'b1; tvalid = 1'b1; tdata = 32'(v); tlast = 1'b0;
          @(posedge clk);
          @(negedge clk);
          m_armed = 1'b0;
          m_wr[0] = 0;
          m_wr[1] = 0;
          chk("midrst_wr",   0, 64'(wrc_v[0]), 64'd0);
          chk("midrst_busy", 0, 64'(busy_v[0]), 64'd0);
          chk("midrst_ready",0, 64'(tready_v[0]), 64'd0);
          rst = 1'b0;
          v   = 0;
          step(1'b1, 1'b1);
          inj_val = m_start[0] + 30;
        end
        cyc++;
      end
      if (cyc >= 1500) begin
        total++;
        bad++;
        $display("FAIL timeout row %0d cycles=%0d", r, cyc);
      end
`ifdef AXIS_FRAME_CAPTURE_SOF_ALIGN_EN
      exp_err = tbl[r].inject;
`else
      exp_err = tbl[r].err_nm;
`endif
      // Idle beats after completion must leave the result untouched.
      repeat (3) step(1'b1, 1'b0);
      check_state(0);
      chk("tlast_err", 0, 64'(err_v[0]), 64'(exp_err));
      if (tbl[r].chk_skip) begin
        check_state(1);
        chk("tlast_err", 1, 64'(err_v[1]), 64'(exp_err));
      end
      tvalid = 1'b0;
      for (int k = 0; k < D; k++) begin
        rd_addr = 6'(k);
        @(posedge clk);
        @(negedge clk);
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        chk("rd_data", 0, 64'(rdd_v[0]), 64'(32'(e0)));
        if (tbl[r].chk_skip) chk("rd_data", 1, 64'(rdd_v[1]), 64'(32'(e1)));
      end
      // Re-arm from DONE clears the sticky error and the count.
      step(1'b1, 1'b1);
      check_state(0);
      chk("rearm_err", 0, 64'(err_v[0]), 64'd0);
      if (tbl[r].chk_skip) begin
        check_state(1);
        chk("rearm_err", 1, 64'(err_v[1]), 64'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_frame_capture.md
Name: axis_frame_capture

Overview:
- Single-clock AXI4-Stream sink that sits directly downstream of the OSPFB output (FFT/phase-compensation stage).
- Captures a fixed number of complex output samples into an internal RAM and raises `full` when the capture is complete. The bench or host then reads the RAM back.
- Optionally discards a programmable number of whole frames before capturing.
- Checks `tlast` framing against the FFT length and records framing errors.
- The sink never back-pressures the OSPFB.

Parameters:
- WIDTH, 16, bits per real/imag component; tdata is 2*WIDTH wide, {im, re}.
- DEPTH, 64, samples captured per arm (power of 2, >=2).
- FRAME_LEN, 64, beats per frame (FFT_LEN); sets the expected tlast position.
- SKIP_FRAMES, 0, whole frames discarded after arm before capture starts.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  single-cycle pulse; starts a capture from IDLE or DONE.
- s_axis_tdata  in  2*WIDTH  sample {im, re}.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tlast  in  1  last beat of a frame.
- s_axis_tready  out  1  sink ready.
- rd_addr  in  $clog2(DEPTH)  readback address.
- rd_data  out  2*WIDTH  registered RAM read data.
- full  out  1  capture complete.
- busy  out  1  state is SKIP, SYNC or CAPTURE.
- wr_count  out  $clog2(DEPTH)+1  samples written in the current capture.
- tlast_err  out  1  sticky framing error.

Behaviour:
- Reset values:
  - state = IDLE.
  - s_axis_tready, full, busy, tlast_err, wr_count, rd_data = 0.
  - Beat and frame counters = 0.
  - RAM contents are not cleared.
- Beat definition: a beat is any cycle with s_axis_tvalid & s_axis_tready.
- tready rule: s_axis_tready = 1 in every state except while rst is high. Beats in IDLE and DONE are accepted and dropped, so the upstream never stalls.
- States and transitions:
  - IDLE: arm -> SYNC if the macro below is defined; otherwise -> SKIP when SKIP_FRAMES>0, else -> CAPTURE.
  - SYNC: covered under Optional Feature.
  - SKIP: counts beats with tlast. On the SKIP_FRAMES-th tlast beat -> CAPTURE; that tlast beat is discarded.
  - CAPTURE: each beat writes tdata to RAM[wr_count] and increments wr_count. When the beat that brings wr_count to DEPTH is written -> DONE, and full = 1 on the following cycle.
  - DONE: holds full = 1 and wr_count = DEPTH. arm -> clears full, wr_count and tlast_err, then follows the IDLE transition rules.
- arm handling:
  - arm is ignored in SKIP, SYNC and CAPTURE.
  - A beat in the same cycle as arm is not captured; capture eligibility begins the cycle after arm.
- Write address: never wraps; writes are blocked once wr_count = DEPTH.
- Framing check:
  - The beat counter runs mod FRAME_LEN on every beat while busy.
  - tlast_err sets if tlast=1 at a beat index other than FRAME_LEN-1, or tlast=0 at index FRAME_LEN-1.
  - On any tlast beat, the counter resyncs to 0 for the next beat.
  - tlast_err is sticky until arm (from DONE) or rst.
- Readback:
  - rd_data <= RAM[rd_addr] every cycle, 1-cycle latency, independent of state.
  - Read and write to the same address in the same cycle returns the old data.
- Reset mid-operation: rst during any state returns to IDLE with all outputs at reset values; an in-flight beat in the rst cycle is not written.
- busy = 1 only in SKIP, SYNC and CAPTURE.

Optional Feature:
- Macro: AXIS_FRAME_CAPTURE_SOF_ALIGN_EN.
- When defined:
  - arm moves IDLE/DONE -> SYNC.
  - SYNC discards beats until a tlast beat, then goes -> SKIP (SKIP_FRAMES>0) or -> CAPTURE.
  - The beat counter is forced to 0 at that point, so the first captured sample is always frame bin 0.
  - No framing check runs in SYNC.
- When undefined:
  - SYNC is absent.
  - The beat counter resets to 0 on arm, so the first beat after arm is treated as bin 0.

Test Plan:
- Reset held 10 cycles, then released, no arm -> tready=1, full=0, wr_count=0, rd_data=0; 20 counter beats are dropped and wr_count stays 0.
- arm, then a counter stream 0,1,2,... with tvalid=1 and tlast every 64th beat (DEPTH=64, SKIP_FRAMES=0) -> full rises 1 cycle after beat 63; readback of addr k returns k for k=0..63; tlast_err=0.
- SKIP_FRAMES=2, same stream -> RAM[0]=128, RAM[63]=191; busy=1 throughout skip and capture.
- tlast injected at beat 30 of the first frame -> tlast_err=1 and stays 1 through DONE; a new arm clears it.
- tvalid toggled pseudo-randomly at 50% -> RAM contents are identical to the gapless case; wr_count counts only valid beats; full rises exactly after the 64th valid beat.
- rst asserted at wr_count=20 mid-capture, then re-arm -> wr_count restarts at 0 and the capture completes normally. With the macro defined and arm at beat 10 of a frame -> RAM[0] holds the first beat after the next tlast (value 64).
